// File: rtl/pc_sequencer.sv
// Next-fetch-address selection and interrupt entry; redirects reach pc one cycle later, interrupts DRAIN_CYCLES+1 later.
// stall holds pc in RUN and in the vector cycle; DRAIN ignores stall and redirect inputs.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] INT_VECTOR   = 32'h0000_0008,
    parameter int          DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        eret,
    input  logic        int_req,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        flush_if,
    output logic [31:0] epc,
    output logic        int_ack,
    output logic        in_handler
);

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_VECTOR
    } state_t;

    localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

    state_t      state;
    logic [2:0]  drain_cnt;
    logic [31:0] npc_seq;
    logic        redirect;
    logic        eret_ok;

    assign pc_plus4 = pc + 32'd4;
    assign eret_ok  = eret && in_handler;

    // Address RUN would load this cycle; also the return address saved on interrupt entry.
    always_comb begin
        npc_seq  = pc_plus4;
        redirect = 1'b0;
        if (eret_ok) begin
            npc_seq  = epc;
            redirect = 1'b1;
        end else if (br_taken) begin
            npc_seq  = {br_target[31:2], 2'b00};
            redirect = 1'b1;
        end else if (jump) begin
            npc_seq  = {jump_target[31:2], 2'b00};
            redirect = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state      <= S_RUN;
            drain_cnt  <= 3'd0;
            pc         <= RESET_PC;
            epc        <= 32'd0;
            flush_if   <= 1'b0;
            int_ack    <= 1'b0;
            in_handler <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    int_ack <= 1'b0;
                    if (stall) begin
                        flush_if <= 1'b0;
                    end else if (int_req && !in_handler) begin
                        epc       <= {npc_seq[31:2], 2'b00};
                        flush_if  <= 1'b1;
                        drain_cnt <= DRAIN_LOAD;
                        state     <= S_DRAIN;
                    end else begin
                        pc       <= npc_seq;
                        flush_if <= redirect;
                        if (eret_ok) begin
                            in_handler <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    flush_if <= 1'b1;
                    if (drain_cnt == 3'd0) begin
                        pc         <= INT_VECTOR;
                        int_ack    <= 1'b1;
                        in_handler <= 1'b1;
                        state      <= S_VECTOR;
                    end else begin
                        drain_cnt <= drain_cnt - 3'd1;
                    end
                end
                S_VECTOR: begin
                    // Vector cycle fetches the handler's first word, so it must not be flushed.
                    int_ack  <= 1'b0;
                    flush_if <= 1'b0;
                    if (!stall) begin
                        pc <= pc_plus4;
                    end
                    state <= S_RUN;
                end
                default: begin
                    state <= S_RUN;
                end
            endcase
        end
    end

endmodule
